mode_output_controller: RTL and testbench

MODE_OUTPUT_CONTROLLER -- requirements
Module: mode_output_controller

---
 rtl/mode_output_controller_if.sv | 49 ++++
 rtl/mode_output_controller.sv | 131 +++++++++++++
 tb/tb_mode_output_controller.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mode_output_controller_if.sv
// mode_output_controller_if
//   Groups the button, pulse, configuration and pin-side signals of
//   mode_output_controller into one bundle.
//   Parameters: NUM_MODES (number of modes), NUM_CH (number of channels).
//   slave modport  : the controller (buttons/config/pulses in, pins out).
//   master modport : whatever drives the controller (sequencer, panel, bench).
//   Signals:
//     sample_tick            button sampling strobe
//     mode_btn_n, dflt_btn_n raw active-low buttons
//     seq_in                 channel values from the pulse-sequence generator
//     slow_pulse, fast_pulse LED flash sources
//     cfg_force_mask/val     per-mode channel overrides, NUM_CH bits per mode
//     cfg_led_sel            per-mode LED source, 2 bits per mode
//     mode, ch_out, led      current mode and registered pin outputs
//     load_defaults          one-clk default reload request
//     mode_changed           one-clk pulse on every mode advance
interface mode_output_controller_if #(
  parameter int NUM_MODES = 4,
  parameter int NUM_CH    = 4
);
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic                        sample_tick;
  logic                        mode_btn_n;
  logic                        dflt_btn_n;
  logic [NUM_CH-1:0]           seq_in;
  logic                        slow_pulse;
  logic                        fast_pulse;
  logic [NUM_MODES*NUM_CH-1:0] cfg_force_mask;
  logic [NUM_MODES*NUM_CH-1:0] cfg_force_val;
  logic [NUM_MODES*2-1:0]      cfg_led_sel;
  logic [MW-1:0]               mode;
  logic [NUM_CH-1:0]           ch_out;
  logic                        led;
  logic                        load_defaults;
  logic                        mode_changed;

  modport slave (
    input  sample_tick, mode_btn_n, dflt_btn_n, seq_in, slow_pulse, fast_pulse,
           cfg_force_mask, cfg_force_val, cfg_led_sel,
    output mode, ch_out, led, load_defaults, mode_changed
  );

  modport master (
    output sample_tick, mode_btn_n, dflt_btn_n, seq_in, slow_pulse, fast_pulse,
           cfg_force_mask, cfg_force_val, cfg_led_sel,
    input  mode, ch_out, led, load_defaults, mode_changed
  );
endinterface

// File: rtl/mode_output_controller.sv
// mode_output_controller
//   Debounces a mode button and a load-defaults button, steps through
//   NUM_MODES operating modes, and drives the channel pins and an LED from
//   per-mode configuration.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  mode_output_controller_if.slave (see interface header)
//   Parameters: NUM_MODES (2..16), NUM_CH (1..16), DEB_SAMPLES (1..15).
module mode_output_controller #(
  parameter int NUM_MODES   = 4,
  parameter int NUM_CH      = 4,
  parameter int DEB_SAMPLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  mode_output_controller_if.slave bus
);
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);
  localparam logic [3:0]    CNT_LAST  = 4'(DEB_SAMPLES - 1);

  // Index 0 = mode button, index 1 = load-defaults button.
  logic [1:0] btn_raw_n;
  logic [1:0] press;  // debounced 0->1 transition this cycle

  assign btn_raw_n = {bus.dflt_btn_n, bus.mode_btn_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic       deb_reg;
      logic [3:0] cnt_reg;
      logic       sample;
      logic       toggle;

      assign sample = ~btn_raw_n[gi];
      // The sample that completes the run flips the state on the same edge,
      // so the compare is against DEB_SAMPLES-1 before the increment.
      assign toggle    = bus.sample_tick && (sample != deb_reg) && (cnt_reg == CNT_LAST);
      assign press[gi] = toggle && sample;

      always_ff @(posedge clk) begin
        if (rst) begin
          deb_reg <= 1'b0;
          cnt_reg <= 4'd0;
        end else if (bus.sample_tick) begin
          if (sample == deb_reg) begin
            cnt_reg <= 4'd0;
          end else if (toggle) begin
            deb_reg <= sample;
            cnt_reg <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
      end
    end
  endgenerate

  logic [MW-1:0]     mode_reg;
  logic [NUM_CH-1:0] ch_out_reg;
  logic              led_reg;
  logic              load_defaults_reg;
  logic              mode_changed_reg;
  logic              pwr_up_reg;  // set through reset, requests the power-up reload

  // Slice out the configuration of the current mode.
  logic [NUM_CH-1:0] cur_mask;
  logic [NUM_CH-1:0] cur_val;
  logic [1:0]        cur_led_sel;

  always_comb begin
    cur_mask    = '0;
    cur_val     = '0;
    cur_led_sel = 2'd0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode_reg == MW'(m)) begin
        cur_mask    = bus.cfg_force_mask[m*NUM_CH +: NUM_CH];
        cur_val     = bus.cfg_force_val[m*NUM_CH +: NUM_CH];
        cur_led_sel = bus.cfg_led_sel[m*2 +: 2];
      end
    end
  end

  logic [NUM_CH-1:0] ch_next;
  logic              led_next;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_next[gi] = cur_mask[gi] ? cur_val[gi] : bus.seq_in[gi];
    end
  endgenerate

  always_comb begin
    led_next = 1'b0;
    case (cur_led_sel)
      2'd0:    led_next = 1'b0;
      2'd1:    led_next = 1'b1;
      2'd2:    led_next = bus.slow_pulse;
      default: led_next = bus.fast_pulse;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg          <= '0;
      ch_out_reg        <= '0;
      led_reg           <= 1'b0;
      load_defaults_reg <= 1'b0;
      mode_changed_reg  <= 1'b0;
      pwr_up_reg        <= 1'b1;
    end else begin
      ch_out_reg        <= ch_next;
      led_reg           <= led_next;
      mode_changed_reg  <= press[0];
      load_defaults_reg <= press[1] | pwr_up_reg;
      pwr_up_reg        <= 1'b0;
      if (press[0]) begin
        // Explicit wrap keeps non-power-of-two mode counts in range.
        mode_reg <= (mode_reg == LAST_MODE) ? '0 : mode_reg + MW'(1);
      end
    end
  end

  assign bus.mode          = mode_reg;
  assign bus.ch_out        = ch_out_reg;
  assign bus.led           = led_reg;
  assign bus.load_defaults = load_defaults_reg;
  assign bus.mode_changed  = mode_changed_reg;
endmodule

// File: tb/tb_mode_output_controller.sv
module tb_mode_output_controller;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus for both instances.
  logic       tick = 1'b0, mb_n = 1'b1, db_n = 1'b1, slow = 1'b0, fast = 1'b0;
  logic [3:0] seq = 4'd0;
  logic [15:0] mask4 = '0, val4 = '0;
  logic [7:0]  led4 = '0;
  logic [11:0] mask3 = '0, val3 = '0;
  logic [5:0]  led3 = '0;
  bit          fix_seq = 1'b0;

  mode_output_controller_if #(.NUM_MODES(4), .NUM_CH(4)) if4 ();
  mode_output_controller_if #(.NUM_MODES(3), .NUM_CH(4)) if3 ();

  assign if4.sample_tick = tick;  assign if3.sample_tick = tick;
  assign if4.mode_btn_n  = mb_n;  assign if3.mode_btn_n  = mb_n;
  assign if4.dflt_btn_n  = db_n;  assign if3.dflt_btn_n  = db_n;
  assign if4.seq_in      = seq;   assign if3.seq_in      = seq;
  assign if4.slow_pulse  = slow;  assign if3.slow_pulse  = slow;
  assign if4.fast_pulse  = fast;  assign if3.fast_pulse  = fast;
  assign if4.cfg_force_mask = mask4; assign if4.cfg_force_val = val4; assign if4.cfg_led_sel = led4;
  assign if3.cfg_force_mask = mask3; assign if3.cfg_force_val = val3; assign if3.cfg_led_sel = led3;

  mode_output_controller #(.NUM_MODES(4), .NUM_CH(4), .DEB_SAMPLES(DEB)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave));
  mode_output_controller #(.NUM_MODES(3), .NUM_CH(4), .DEB_SAMPLES(DEB)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int nmodes[2] = '{4, 3};
  int m_mode[2] = '{0, 0};
  bit m_deb[2]  = '{0, 0};
  bit m_pwr     = 1'b1;
  bit hist_mb[$];  // tick samples disagreeing with the debounced state
  bit hist_db[$];
  int e_mode[2], e_ch[2], e_led[2];
  bit e_ld, e_mc;

  function automatic int fld(input logic [31:0] word, input int idx, input int w);
    return int'((word >> (idx * w)) & ((32'd1 << w) - 1));
  endfunction

  // Returns 1 when this sample completes a debounced press.
  function automatic bit deb_step(input int b, input bit s);
    bit rise = 1'b0;
    if (s == m_deb[b]) begin
      if (b == 0) hist_mb.delete(); else hist_db.delete();
    end else begin
      if (b == 0) hist_mb.push_back(s); else hist_db.push_back(s);
      if (((b == 0) ? hist_mb.size() : hist_db.size()) == DEB) begin
        m_deb[b] = s;
        rise = s;
        if (b == 0) hist_mb.delete(); else hist_db.delete();
      end
    end
    return rise;
  endfunction

  task automatic predict();
    bit rise_m = 1'b0, rise_d = 1'b0;
    if (rst) begin
      m_mode = '{0, 0}; m_deb = '{0, 0}; m_pwr = 1'b1;
      hist_mb.delete(); hist_db.delete();
      e_mode = '{0, 0}; e_ch = '{0, 0}; e_led = '{0, 0};
      e_ld = 1'b0; e_mc = 1'b0;
      return;
    end
    if (tick) begin
      rise_m = deb_step(0, !mb_n);
      rise_d = deb_step(1, !db_n);
    end
    for (int d = 0; d < 2; d++) begin
      int mk, vl, sel;
      mk  = (d == 0) ? fld({16'd0, mask4}, m_mode[d], 4) : fld({20'd0, mask3}, m_mode[d], 4);
      vl  = (d == 0) ? fld({16'd0, val4},  m_mode[d], 4) : fld({20'd0, val3},  m_mode[d], 4);
      sel = (d == 0) ? fld({24'd0, led4},  m_mode[d], 2) : fld({26'd0, led3},  m_mode[d], 2);
      e_ch[d]  = ((int'(seq) & ~mk) | (vl & mk)) & 15;
      e_led[d] = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? int'(slow) : int'(fast);
      if (rise_m) m_mode[d] = (m_mode[d] + 1) % nmodes[d];
      e_mode[d] = m_mode[d];
    end
    e_mc  = rise_m;
    e_ld  = rise_d || m_pwr;
    m_pwr = 1'b0;
  endtask

  // One clock: apply inputs, predict, then compare at the falling edge.
  task automatic run_cycle(input bit t, input bit mb, input bit db);
    tick = t; mb_n = mb; db_n = db;
    if (!fix_seq) seq = 4'($urandom);
    slow = 1'($urandom); fast = 1'($urandom);
    predict();
    @(negedge clk);
    check("mode4", 32'(if4.mode), e_mode[0]);
    check("mode3", 32'(if3.mode), e_mode[1]);
    check("ch4",   32'(if4.ch_out), e_ch[0]);
    check("ch3",   32'(if3.ch_out), e_ch[1]);
    check("led4",  32'(if4.led), e_led[0]);
    check("led3",  32'(if3.led), e_led[1]);
    check("ld4",   32'(if4.load_defaults), 32'(e_ld));
    check("ld3",   32'(if3.load_defaults), 32'(e_ld));
    check("mc4",   32'(if4.mode_changed), 32'(e_mc));
    check("mc3",   32'(if3.mode_changed), 32'(e_mc));
    if (e_mc || e_ld)
      $display("txn t=%0t mode4=%0d mode3=%0d mode_changed=%0b load_defaults=%0b",
               $time, if4.mode, if3.mode, if4.mode_changed, if4.load_defaults);
  endtask

  // A tick followed by three idle clocks, buttons held.
  task automatic tick_hold(input bit mb, input bit db);
    run_cycle(1'b1, mb, db);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, mb, db);
  endtask

  // Clean press: two ticks held, third tick completes and is checked directly.
  task automatic press(input bit with_dflt, input int exp4, input int exp3);
    tick_hold(1'b0, !with_dflt);
    tick_hold(1'b0, !with_dflt);
    run_cycle(1'b1, 1'b0, !with_dflt);
    check("press_mc",   32'(if4.mode_changed), 32'd1);
    check("press_mode4", 32'(if4.mode), 32'(exp4));
    check("press_mode3", 32'(if3.mode), 32'(exp3));
    if (with_dflt) check("press_ld", 32'(if4.load_defaults), 32'd1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, !with_dflt);
    for (int i = 0; i < DEB + 1; i++) tick_hold(1'b1, 1'b1);
  endtask

  initial begin
    bit rmb = 1'b1, rdb = 1'b1;
    mask4 = {4'hF, 4'($urandom), 4'h0, 4'($urandom)};
    val4  = {4'h1, 4'($urandom), 4'($urandom), 4'($urandom)};
    led4  = 8'($urandom);
    mask3 = 12'($urandom); val3 = 12'($urandom); led3 = 6'($urandom);

    // Reset state, then the power-up reload pulse.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b1);
    check("rst_mode", 32'(if4.mode), 32'd0);
    check("rst_ch",   32'(if4.ch_out), 32'd0);
    check("rst_ld",   32'(if4.load_defaults), 32'd0);
    rst = 1'b0;
    run_cycle(1'b0, 1'b1, 1'b1);
    check("pwrup_ld", 32'(if4.load_defaults), 32'd1);
    run_cycle(1'b0, 1'b1, 1'b1);
    check("pwrup_ld_once", 32'(if4.load_defaults), 32'd0);

    // Four presses walk 4 modes back to 0; 3-mode copy goes 1,2,0,1.
    press(1'b0, 1, 1);
    press(1'b0, 2, 2);
    press(1'b0, 3, 0);
    press(1'b0, 0, 1);

    // Two-tick bounce: no change.
    tick_hold(1'b0, 1'b1);
    tick_hold(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick_hold(1'b1, 1'b1);
    check("bounce_mode4", 32'(if4.mode), 32'd0);

    // Mode 1 passes seq_in untouched.
    press(1'b0, 1, 2);
    fix_seq = 1'b1; seq = 4'b1010;
    run_cycle(1'b0, 1'b1, 1'b1);
    check("pass_ch", 32'(if4.ch_out), 32'b1010);
    fix_seq = 1'b0;

    // Mode 3 forces 0001 whatever seq_in does.
    press(1'b0, 2, 0);
    press(1'b0, 3, 1);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 1'b1, 1'b1);
      check("force_ch", 32'(if4.ch_out), 32'b0001);
    end

    // Simultaneous mode and defaults press.
    press(1'b1, 0, 2);

    // Reset mid-press with the button still held.
    tick_hold(1'b0, 1'b1);
    tick_hold(1'b0, 1'b1);
    rst = 1'b1;
    run_cycle(1'b0, 1'b0, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    run_cycle(1'b0, 1'b0, 1'b1);
    check("rst_press_ld", 32'(if4.load_defaults), 32'd1);
    tick_hold(1'b0, 1'b1);
    tick_hold(1'b0, 1'b1);
    check("rst_press_hold", 32'(if4.mode), 32'd0);
    run_cycle(1'b1, 1'b0, 1'b1);
    check("rst_press_adv", 32'(if4.mode), 32'd1);
    for (int i = 0; i < 4; i++) tick_hold(1'b1, 1'b1);

    // Randomised run.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 23) == 0) rmb = !rmb;
      if ($urandom_range(0, 31) == 0) rdb = !rdb;
      if ($urandom_range(0, 199) == 0) begin
        mask4 = 16'($urandom); val4 = 16'($urandom); led4 = 8'($urandom);
        mask3 = 12'($urandom); val3 = 12'($urandom); led3 = 6'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      run_cycle($urandom_range(0, 2) == 0, rmb, rdb);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
